// File: rtl/decode_execute_pipe_pkg.sv
// Shared types for the decode/execute pipeline register: control word,
// its NOP value, and the packed payload carried between the stages.
package decode_execute_pipe_pkg;

  localparam int unsigned PKG_DATA_W = 32;

  // Decoded control word presented to the execute stage.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } control_type;

  localparam control_type CONTROL_NOP = '0;

  // One decoded instruction as held in a pipe slot.
  typedef struct packed {
    logic [PKG_DATA_W-1:0] data1;
    logic [PKG_DATA_W-1:0] data2;
    logic [PKG_DATA_W-1:0] immediate_data;
    control_type           control;
    logic                  compflg;
    logic [PKG_DATA_W-1:0] program_counter;
  } id_ex_payload_t;

  // Pipe occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/decode_execute_skid_slot.sv
// Single payload register with valid bit. Clearing drops valid and forces
// the control word to NOP and compflg to 0 while data fields keep their value.
module decode_execute_skid_slot
  import decode_execute_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           clear,
  input  id_ex_payload_t d,
  output id_ex_payload_t q,
  output logic           valid
);

  // Load has priority over clear; clear keeps data for a stable bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clear) begin
      valid     <= 1'b0;
      q.control <= CONTROL_NOP;
      q.compflg <= 1'b0;
    end
  end

endmodule

// File: rtl/decode_execute_pipe.sv
// Decode -> execute pipeline register with valid/ready handshake and flush.
// Optional macro DECODE_EXECUTE_PIPE_SKID_EN selects a 2-entry skid buffer
// with registered in_ready; otherwise a single entry with combinational
// in_ready. All bus outputs come straight from the head slot registers.
module decode_execute_pipe
  import decode_execute_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PKG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [DATA_W-1:0] immediate_data_in,
  input  control_type       control_in,
  input  logic              compflg_in,
  input  logic [DATA_W-1:0] program_counter_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] immediate_data,
  output control_type       control_out,
  output logic              compflg,
  output logic [DATA_W-1:0] program_counter
);

  id_ex_payload_t in_pl;
  id_ex_payload_t head_d;
  id_ex_payload_t head_q;
  logic           head_load;
  logic           head_clear;
  logic           head_valid;
  logic           in_xfer;
  logic           out_xfer;
  occ_state_e     state_q;
  occ_state_e     state_d;

  // Pack incoming decode fields into a payload.
  always_comb begin
    in_pl                 = '0;
    in_pl.data1           = PKG_DATA_W'(data1_in);
    in_pl.data2           = PKG_DATA_W'(data2_in);
    in_pl.immediate_data  = PKG_DATA_W'(immediate_data_in);
    in_pl.control         = control_in;
    in_pl.compflg         = compflg_in;
    in_pl.program_counter = PKG_DATA_W'(program_counter_in);
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = head_valid & out_ready;
  assign out_valid = head_valid;

  assign data1           = DATA_W'(head_q.data1);
  assign data2           = DATA_W'(head_q.data2);
  assign immediate_data  = DATA_W'(head_q.immediate_data);
  assign control_out     = head_q.control;
  assign compflg         = head_q.compflg;
  assign program_counter = DATA_W'(head_q.program_counter);

`ifdef DECODE_EXECUTE_PIPE_SKID_EN
  id_ex_payload_t skid_q;
  logic           skid_load;
  logic           skid_clear;
  logic           skid_valid;
  logic           in_ready_q;

  assign in_ready = in_ready_q;

  // Occupancy transitions and slot load/clear controls.
  always_comb begin
    state_d    = state_q;
    head_d     = in_pl;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            head_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_xfer) begin
            head_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer && skid_valid) begin
            head_d     = skid_q;
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  decode_execute_skid_slot u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pl),
    .q     (skid_q),
    .valid (skid_valid)
  );
`else
  assign in_ready = ~head_valid | out_ready;

  // Single-entry occupancy: replace on accept, drop on consume or flush.
  always_comb begin
    state_d    = state_q;
    head_d     = in_pl;
    head_load  = 1'b0;
    head_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      head_clear = 1'b1;
    end else if (in_xfer) begin
      head_load = 1'b1;
      state_d   = ONE;
    end else if (out_xfer) begin
      head_clear = 1'b1;
      state_d    = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end
`endif

  decode_execute_skid_slot u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head_q),
    .valid (head_valid)
  );

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Self-checking bench for decode_execute_pipe; expectations follow
// DECODE_EXECUTE_PIPE_SKID_EN when it is defined.
module tb_decode_execute_pipe;
  import decode_execute_pipe_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data1_in = '0;
  logic [W-1:0]  data2_in = '0;
  logic [W-1:0]  immediate_data_in = '0;
  control_type   control_in = CONTROL_NOP;
  logic          compflg_in = 1'b0;
  logic [W-1:0]  program_counter_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data1;
  logic [W-1:0]  data2;
  logic [W-1:0]  immediate_data;
  control_type   control_out;
  logic          compflg;
  logic [W-1:0]  program_counter;

  int n_checks = 0;
  int n_fail   = 0;

  decode_execute_pipe #(.DATA_W(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .data1_in           (data1_in),
    .data2_in           (data2_in),
    .immediate_data_in  (immediate_data_in),
    .control_in         (control_in),
    .compflg_in         (compflg_in),
    .program_counter_in (program_counter_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .data1              (data1),
    .data2              (data2),
    .immediate_data     (immediate_data),
    .control_out        (control_out),
    .compflg            (compflg),
    .program_counter    (program_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d1;
    logic [W-1:0] pc;
    logic         cf;
    logic         ov_e;
    logic [W-1:0] d1_e;
    logic [W-1:0] pc_e;
    logic         cf_e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic control_type mk_ctrl(input logic [W-1:0] k);
    control_type c;
    c           = CONTROL_NOP;
    c.alu_op    = 4'(k);
    c.reg_write = 1'b1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d1, input logic [W-1:0] pc, input logic cf);
    in_valid           = iv;
    data1_in           = d1;
    data2_in           = d1 << 8;
    immediate_data_in  = d1 << 16;
    control_in         = mk_ctrl(d1);
    compflg_in         = cf;
    program_counter_in = pc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
    check({tag, "_in_ready"},  64'(in_ready),  64'(1'b1));
    check({tag, "_control"},   64'(control_out), 64'(CONTROL_NOP));
    check({tag, "_compflg"},   64'(compflg), 64'(1'b0));
    check({tag, "_data1"},     64'(data1), 64'(0));
    check({tag, "_data2"},     64'(data2), 64'(0));
    check({tag, "_imm"},       64'(immediate_data), 64'(0));
    check({tag, "_pc"},        64'(program_counter), 64'(0));
  endtask

  vec_t vecs[9];
  logic [W-1:0] bp_data[3];
  logic         bp_rdy_e[4];
  int           acc;

  initial begin
    vecs[0] = '{1'b1, 32'd1, 32'h100, 1'b0, 1'b1, 32'd1, 32'h100, 1'b0};
    vecs[1] = '{1'b1, 32'd2, 32'h104, 1'b0, 1'b1, 32'd2, 32'h104, 1'b0};
    vecs[2] = '{1'b1, 32'd3, 32'h108, 1'b1, 1'b1, 32'd3, 32'h108, 1'b1};
    vecs[3] = '{1'b1, 32'd4, 32'h10C, 1'b0, 1'b1, 32'd4, 32'h10C, 1'b0};
    vecs[4] = '{1'b1, 32'd5, 32'h110, 1'b0, 1'b1, 32'd5, 32'h110, 1'b0};
    vecs[5] = '{1'b1, 32'd6, 32'h114, 1'b0, 1'b1, 32'd6, 32'h114, 1'b0};
    vecs[6] = '{1'b1, 32'd7, 32'h118, 1'b0, 1'b1, 32'd7, 32'h118, 1'b0};
    vecs[7] = '{1'b1, 32'd8, 32'h11C, 1'b0, 1'b1, 32'd8, 32'h11C, 1'b0};
    vecs[8] = '{1'b0, 32'd0, 32'h0,   1'b0, 1'b0, 32'd8, 32'h11C, 1'b0};

    bp_data[0] = 32'hA;
    bp_data[1] = 32'hB;
    bp_data[2] = 32'hC;
`ifdef DECODE_EXECUTE_PIPE_SKID_EN
    bp_rdy_e[0] = 1'b1; bp_rdy_e[1] = 1'b1; bp_rdy_e[2] = 1'b0; bp_rdy_e[3] = 1'b0;
`else
    bp_rdy_e[0] = 1'b1; bp_rdy_e[1] = 1'b0; bp_rdy_e[2] = 1'b0; bp_rdy_e[3] = 1'b0;
`endif

    // Reset then idle.
    #1;
    check_reset_state("in_reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_reset_state("idle");

    // Streaming with a compressed beat 3.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].iv, vecs[i].d1, vecs[i].pc, vecs[i].cf);
      #1;
      check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'(1'b1));
      tick();
      check($sformatf("stream%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov_e));
      check($sformatf("stream%0d_data1", i), 64'(data1), 64'(vecs[i].d1_e));
      check($sformatf("stream%0d_data2", i), 64'(data2), 64'(vecs[i].d1_e << 8));
      check($sformatf("stream%0d_imm", i), 64'(immediate_data), 64'(vecs[i].d1_e << 16));
      check($sformatf("stream%0d_pc", i), 64'(program_counter), 64'(vecs[i].pc_e));
      check($sformatf("stream%0d_compflg", i), 64'(compflg), 64'(vecs[i].cf_e));
      check($sformatf("stream%0d_control", i), 64'(control_out),
            64'(vecs[i].ov_e ? mk_ctrl(vecs[i].d1_e) : CONTROL_NOP));
    end

    // Back-pressure: out_ready low for 4 cycles with offers 0xA, 0xB, 0xC.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, bp_data[acc], 32'h200 + 32'(4 * acc), 1'b0);
      #1;
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'(bp_rdy_e[c]));
      if (bp_rdy_e[c]) acc++;
      tick();
    end
    check("bp_held_valid", 64'(out_valid), 64'(1'b1));
    check("bp_held_data1", 64'(data1), 64'(32'hA));
    check("bp_held_pc", 64'(program_counter), 64'(32'h200));
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick();
`ifdef DECODE_EXECUTE_PIPE_SKID_EN
    check("bp_drain_b_valid", 64'(out_valid), 64'(1'b1));
    check("bp_drain_b_data1", 64'(data1), 64'(32'hB));
    check("bp_drain_b_pc", 64'(program_counter), 64'(32'h204));
    tick();
`endif
    check("bp_drained_valid", 64'(out_valid), 64'(1'b0));
    check("bp_drained_control", 64'(control_out), 64'(CONTROL_NOP));

    // Flush with the pipe full and a new beat 0x55 offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h300, 1'b1);
    tick();
`ifdef DECODE_EXECUTE_PIPE_SKID_EN
    drive(1'b1, 32'h22, 32'h304, 1'b0);
    tick();
    check("pre_flush_in_ready", 64'(in_ready), 64'(1'b0));
`endif
    drive(1'b1, 32'h55, 32'h308, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'(1'b0));
    check("flush_control", 64'(control_out), 64'(CONTROL_NOP));
    check("flush_compflg", 64'(compflg), 64'(1'b0));
    check("flush_in_ready", 64'(in_ready), 64'(1'b1));
    check("flush_data1_hold", 64'(data1), 64'(32'h11));
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_flush%0d_out_valid", c), 64'(out_valid), 64'(1'b0));
      check($sformatf("post_flush%0d_data1", c), 64'(data1), 64'(32'h11));
    end

    // Async reset pulse between clock edges.
    drive(1'b1, 32'h61, 32'h400, 1'b0);
    tick();
    check("pre_rst_data1", 64'(data1), 64'(32'h61));
    drive(1'b1, 32'h62, 32'h404, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h63, 32'h408, 1'b0);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'(1'b1));
    check("post_rst_data1", 64'(data1), 64'(32'h63));
    check("post_rst_pc", 64'(program_counter), 64'(32'h408));
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("post_rst_idle_valid", 64'(out_valid), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
